// File: rtl/seq_gen_if.sv
// seq_gen_if: control and serial-output bundle for the seq_gen pattern generator.
// The slave side is seq_gen itself; the master side is whoever requests frames.
// Optional feature macro: SEQ_GEN_REPEAT_EN adds the loop-request signal 'rpt'.
// The loop request is called 'rpt' because 'repeat' is a reserved word in SystemVerilog.
interface seq_gen_if #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] len;
    logic             stop;
`ifdef SEQ_GEN_REPEAT_EN
    logic             rpt;
`endif
    logic             o;
    logic             o_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, len, stop,
`ifdef SEQ_GEN_REPEAT_EN
        output rpt,
`endif
        input  o, o_valid, busy, done
    );

    modport slave (
        input  start, pattern, len, stop,
`ifdef SEQ_GEN_REPEAT_EN
        input  rpt,
`endif
        output o, o_valid, busy, done
    );
endinterface

// File: rtl/seq_gen.sv
// seq_gen: serial pattern generator. A start request in IDLE captures a WIDTH-bit
// pattern and an effective length N, then the pattern is shifted out LSB-first,
// one bit per clock, with o_valid/busy high. A one-cycle done pulse marks normal
// completion; stop aborts the frame without done.
// Optional feature macro: SEQ_GEN_REPEAT_EN keeps a copy of the captured pattern and
// length so that the frame can be looped back-to-back while 'rpt' is held high.
module seq_gen #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 4
) (
    input logic     clk,
    input logic     rst_n,
    seq_gen_if.slave bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sh;       // bit 0 is the bit currently on 'o'; zero in IDLE
    logic [CNT_W-1:0] cnt;      // bits still to present, including the current one
    logic             done_q;
    logic [CNT_W-1:0] eff_len;

`ifdef SEQ_GEN_REPEAT_EN
    logic [WIDTH-1:0] pat_cap;
    logic [CNT_W-1:0] n_cap;
`endif

    // Effective frame length: zero or oversize requests mean a full WIDTH-bit frame.
    always_comb begin
        // NOTE: the default assignment first keeps this block purely combinational (no latch).
        eff_len = bus.len;
        if (bus.len == '0 || bus.len > CNT_W'(WIDTH))
            eff_len = CNT_W'(WIDTH);
    end

    // Frame sequencing: capture in IDLE, shift and count down in SEND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh      <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
            pat_cap <= '0;
            n_cap   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= SEND;
                        sh      <= bus.pattern;
                        cnt     <= eff_len;
`ifdef SEQ_GEN_REPEAT_EN
                        pat_cap <= bus.pattern;
                        n_cap   <= eff_len;
`endif
                    end
                end
                SEND: begin
                    if (bus.stop) begin
                        // Abort takes priority over completion and never raises done.
                        state <= IDLE;
                        sh    <= '0;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(1)) begin
                        done_q <= 1'b1;
`ifdef SEQ_GEN_REPEAT_EN
                        if (bus.rpt) begin
                            // Reload so bit 0 of the next frame follows with no gap.
                            sh  <= pat_cap;
                            cnt <= n_cap;
                        end else begin
                            state <= IDLE;
                            sh    <= '0;
                            cnt   <= '0;
                        end
`else
                        state <= IDLE;
                        sh    <= '0;
                        cnt   <= '0;
`endif
                    end else begin
                        sh  <= {1'b0, sh[WIDTH-1:1]};
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs come straight from registers; sh is cleared whenever the FSM is idle.
    assign bus.o       = sh[0];
    assign bus.o_valid = (state == SEND);
    assign bus.busy    = (state == SEND);
    assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: self-checking bench for seq_gen (WIDTH=10, CNT_W=4).
// Table-driven frames, hand-written corner sequences and randomized traffic
// compared with a frame-level reference model. Honours SEQ_GEN_REPEAT_EN.
module tb_seq_gen;

    localparam int WIDTH = 10;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;

    seq_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    seq_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a frame is a captured pattern, a length N and the index of the bit shown.
    bit         m_send;
    bit         m_done;
    logic [9:0] m_pat;
    int         m_n;
    int         m_k;

    typedef struct {
        logic       start;
        logic [3:0] len;
        logic [9:0] pattern;
        logic       exp_o;
        logic       exp_valid;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_len(input logic [3:0] l);
        if (l == 4'd0 || int'(l) > WIDTH) return WIDTH;
        return int'(l);
    endfunction

    function automatic bit rpt_now();
`ifdef SEQ_GEN_REPEAT_EN
        return bus.rpt;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        m_send = 1'b0;
        m_done = 1'b0;
        m_k    = 0;
        m_n    = 0;
        m_pat  = '0;
    endfunction

    // Advance the model with the inputs currently presented, then clock the DUT.
    task automatic tick();
        if (!m_send) begin
            m_done = 1'b0;
            if (bus.start) begin
                m_send = 1'b1;
                m_pat  = bus.pattern;
                m_n    = eff_len(bus.len);
                m_k    = 0;
            end
        end else if (bus.stop) begin
            m_send = 1'b0;
            m_done = 1'b0;
        end else if (m_k == m_n - 1) begin
            m_done = 1'b1;
            if (rpt_now()) m_k = 0;
            else           m_send = 1'b0;
        end else begin
            m_k++;
            m_done = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk1({tag, "_o"},     bus.o,       m_send ? m_pat[m_k] : 1'b0);
        chk1({tag, "_valid"}, bus.o_valid, m_send);
        chk1({tag, "_busy"},  bus.busy,    m_send);
        chk1({tag, "_done"},  bus.done,    m_done);
    endtask

    task automatic check_zero(input string tag);
        chk1({tag, "_o"},     bus.o,       1'b0);
        chk1({tag, "_valid"}, bus.o_valid, 1'b0);
        chk1({tag, "_busy"},  bus.busy,    1'b0);
        chk1({tag, "_done"},  bus.done,    1'b0);
    endtask

    task automatic add(input logic s, input logic [3:0] l, input logic [9:0] p,
                       input logic eo, input logic ev, input logic ed);
        vec_t v;
        v.start = s; v.len = l; v.pattern = p;
        v.exp_o = eo; v.exp_valid = ev; v.exp_done = ed;
        vecs.push_back(v);
    endtask

    initial begin
        logic [9:0] p_full;
        bit         vhist[16];
        int         cnt_v;
        int         last_i;
        int         next_i;

        p_full = 10'b0001101011;

        // Full frame, len=0 -> 10 bits: 1,1,0,1,0,1,1,0,0,0 then done.
        add(1'b1, 4'd0, p_full, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'd0, p_full, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'd0, p_full, 1'b0, 1'b1, 1'b0);
        add(1'b0, 4'd0, p_full, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'd0, p_full, 1'b0, 1'b1, 1'b0);
        add(1'b0, 4'd0, p_full, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'd0, p_full, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'd0, p_full, 1'b0, 1'b1, 1'b0);
        add(1'b0, 4'd0, p_full, 1'b0, 1'b1, 1'b0);
        add(1'b0, 4'd0, p_full, 1'b0, 1'b1, 1'b0);
        add(1'b0, 4'd0, p_full, 1'b0, 1'b0, 1'b1);
        add(1'b0, 4'd0, p_full, 1'b0, 1'b0, 1'b0);
        // Short frame, len=4 -> 1,1,0,1 then done.
        add(1'b1, 4'd4, p_full, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'd4, p_full, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'd4, p_full, 1'b0, 1'b1, 1'b0);
        add(1'b0, 4'd4, p_full, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'd4, p_full, 1'b0, 1'b0, 1'b1);
        add(1'b0, 4'd4, p_full, 1'b0, 1'b0, 1'b0);

        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.len     = '0;
        bus.pattern = '0;
`ifdef SEQ_GEN_REPEAT_EN
        bus.rpt     = 1'b0;
`endif
        model_reset();

        // Reset asserted mid-cycle clears the outputs without waiting for a clock edge.
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_model("idle");
        end

        // Table-driven frames.
        for (int i = 0; i < vecs.size(); i++) begin
            bus.start   = vecs[i].start;
            bus.len     = vecs[i].len;
            bus.pattern = vecs[i].pattern;
            tick();
            chk1($sformatf("vec%0d_o", i),     bus.o,       vecs[i].exp_o);
            chk1($sformatf("vec%0d_valid", i), bus.o_valid, vecs[i].exp_valid);
            chk1($sformatf("vec%0d_busy", i),  bus.busy,    vecs[i].exp_valid);
            chk1($sformatf("vec%0d_done", i),  bus.done,    vecs[i].exp_done);
        end
        bus.start = 1'b0;

        // len=15 clamps to 10 bits.
        cnt_v = 0;
        for (int i = 0; i < 14; i++) begin
            bus.start   = (i == 0);
            bus.len     = 4'd15;
            bus.pattern = 10'b1011001110;
            tick();
            check_model("clamp");
            if (bus.o_valid) cnt_v++;
        end
        chk_int("clamp_bits", cnt_v, 10);

        // start while showing bit 3 is ignored; pattern changes after capture have no effect.
        for (int i = 0; i < 12; i++) begin
            bus.start   = (i == 0 || i == 4);
            bus.len     = 4'd0;
            bus.pattern = (i == 0) ? p_full : 10'($urandom);
            tick();
            check_model("ignore");
            chk1("ignore_done_time", bus.done, i == 10);
        end
        bus.start = 1'b0;

        // start held high: next frame's bit 0 comes 2 cycles after the last bit.
        bus.pattern = 10'b0000000101;
        bus.len     = 4'd3;
        bus.start   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_model("b2b");
            vhist[i] = bus.o_valid;
        end
        bus.start = 1'b0;
        last_i = -1;
        next_i = -1;
        for (int i = 0; i < 11; i++)
            if (last_i < 0 && vhist[i] && !vhist[i+1]) last_i = i;
        for (int i = 0; i < 12; i++)
            if (last_i >= 0 && next_i < 0 && i > last_i && vhist[i]) next_i = i;
        chk_int("b2b_gap", next_i - last_i, 2);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_model("b2b_drain");
        end

        // stop at bit 5: idle next edge with no done.
        bus.pattern = p_full;
        bus.len     = 4'd0;
        for (int i = 0; i < 10; i++) begin
            bus.start = (i == 0);
            bus.stop  = (i == 6);
            tick();
            check_model("stop");
            if (i >= 6) begin
                chk1("stop_valid", bus.o_valid, 1'b0);
                chk1("stop_done",  bus.done,    1'b0);
            end
        end
        bus.stop = 1'b0;

        // Asynchronous reset at bit 2, then a fresh full frame from bit 0.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check_model("prerst");
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.start = (i == 0);
            tick();
            check_model("postrst");
        end

`ifdef SEQ_GEN_REPEAT_EN
        // Looping a 3-bit frame: 1,0,1,1,0,1,... with done on each boundary.
        bus.pattern = 10'b0000000101;
        bus.len     = 4'd3;
        bus.rpt     = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.start = (i == 0);
            tick();
            check_model("rpt");
            chk1("rpt_o",    bus.o,    (i % 3) != 1);
            chk1("rpt_done", bus.done, (i > 0) && (i % 3 == 0));
            chk1("rpt_busy", bus.busy, 1'b1);
        end
        bus.rpt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_model("rpt_drop");
        end
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.start   = ($urandom_range(3) == 0);
            bus.stop    = ($urandom_range(15) == 0);
            bus.len     = 4'($urandom_range(15));
            bus.pattern = 10'($urandom);
`ifdef SEQ_GEN_REPEAT_EN
            if ($urandom_range(7) == 0) bus.rpt = ~bus.rpt;
`endif
            tick();
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern generator: captures a WIDTH-bit pattern on a start request and shifts it out LSB-first, one bit per clock, with a valid qualifier. It is the transmit end for the serial sequence detector `SD`. Its `o` output drives the detector's `i` input directly, so detector benches and on-board self-test get a cycle-exact source stream in place of ad-hoc shift loops.

## Interface
- `WIDTH`, 10, maximum pattern length in bits (≥2)
- `CNT_W`, 4, width of `len` and the internal bit counter; must satisfy 2^CNT_W > WIDTH

- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request to begin a frame; sampled only in IDLE
- `pattern`  in  WIDTH  bits to send, bit 0 first; captured on the accepting edge
- `len`  in  CNT_W  number of bits to send; captured with `pattern`
- `stop`  in  1  abort the current frame
- `repeat`  in  1  loop the frame (present only with `SEQ_GEN_REPEAT_EN`)
- `o`  out  1  serial data bit; connects to `SD.i`
- `o_valid`  out  1  high while `o` carries a frame bit
- `busy`  out  1  high in SEND
- `done`  out  1  one-cycle pulse at normal frame completion

## Operation
- FSM has two states: IDLE and SEND. All outputs are registered.
- Reset (async, `rst_n`=0): state IDLE. `o`=0, `o_valid`=0, `busy`=0, `done`=0. Shift register and counter are cleared.
- IDLE → SEND: on an edge with `start`=1, capture `pattern` into the shift register and the effective length N into the counter.
- Effective length N: `len`=0 gives N=WIDTH; `len`>WIDTH is clamped to WIDTH; otherwise N=`len`.
- SEND: `o` = shift register bit 0, `o_valid`=1, `busy`=1. Each edge shifts right by one (zero fill) and decrements the counter.
- SEND → IDLE after N bits: `o`=0, `o_valid`=0, `busy`=0, `done`=1 for exactly one cycle.
- `start` during SEND is ignored; it is not queued.
- `start` in the `done` cycle is accepted, because the FSM is already in IDLE. The result is a one-idle-cycle gap between frames.
- `stop`=1 in SEND: the next edge returns to IDLE with outputs as after reset and `done`=0. `stop` has priority over frame completion. `stop` in IDLE has no effect, and `start` is still honoured.
- `pattern`/`len` changes after capture do not affect the frame in flight.

## Timing
- Edge E0 samples `start`=1 in IDLE. After E0, `o`=pattern[0] and `o_valid`=1.
- After edge Ek (1≤k≤N−1), `o`=pattern[k].
- After edge EN: IDLE, `done`=1. Start-to-first-bit latency is 1 cycle; frame occupancy is N cycles.
- `SD` samples `o` on the edge following its presentation, so each bit is stable for one full clock period.
- Minimum `start` pulse is 1 cycle. Holding `start` high gives continuous frames with one idle cycle between them.

## Configuration
- `SEQ_GEN_REPEAT_EN` defined: adds the `repeat` port.
  - If `repeat`=1 at edge EN, the FSM stays in SEND and reloads the captured pattern and N, so `o`=pattern[0] with no gap.
  - `done` pulses for one cycle at each frame boundary, coincident with bit 0 of the next frame, and `busy` stays 1.
  - `stop` still aborts.
- `SEQ_GEN_REPEAT_EN` undefined: no `repeat` port, one-shot behaviour only. The captured pattern copy is not synthesised.

## Test plan
- Reset then idle: `rst_n`=0 asserted mid-cycle → all outputs 0 immediately. After release with `start`=0 for 5 cycles → `o_valid`=0 and `busy`=0 throughout.
- Full frame: `pattern`=10'b0001101011, `len`=0, 1-cycle `start` → `o` = 1,1,0,1,0,1,1,0,0,0 over 10 cycles with `o_valid`=1. Then `done`=1 for one cycle. Chained into `SD`, the detector output matches its golden model.
- Short frame with clamp: `len`=4 → `o` = 1,1,0,1 then `done`. `len`=15 → 10 bits sent.
- Ignored start and back-to-back: `start` pulsed at bit 3 → frame unchanged. `start` held high → second frame's bit 0 appears 2 cycles after the first frame's last bit.
- Abort and reset mid-frame: `stop` at bit 5 → IDLE next edge, no `done`. `rst_n` low at bit 2 → outputs 0 asynchronously. A new `start` after release sends the full frame from bit 0.
- Repeat (macro defined): `repeat`=1, `len`=3, `pattern`=3'b101 → `o` = 1,0,1,1,0,1,… with no gap and `done` pulsing every 3 cycles. Dropping `repeat` → the current frame ends and the FSM goes to IDLE.
